// File: rtl/raw_frame_sequencer.sv
// -----------------------------------------------------------------------------
// raw_frame_sequencer
//
// Video timing sequencer for the raw-video simulation chain. Generates the
// frame-valid (frame_vsync), line-valid (frame_href) and pixel-enable
// (frame_clken) strobes that feed the RGB-to-Bayer mosaic stage. It also
// produces pixel coordinates and a Bayer pattern selector that is latched only
// on frame boundaries.
//
// Configuration macro:
//   RAW_SEQ_CONT_EN  defined   -> continuous mode. After GAP the next frame
//                                 starts automatically unless a stop is pending.
//                    undefined -> single-shot. Every frame needs its own start.
//
// Parameters:
//   H_ACTIVE  active pixels per line
//   H_BLANK   horizontal blanking cycles; also the vsync-to-first-href lead
//   V_ACTIVE  active lines per frame
//   V_GAP     cycles with vsync low between frames
//   CNT_W     width of pixel_x, pixel_y and the internal cycle counter
//
// Ports:
//   clk           pixel clock
//   rst_n         asynchronous, active-low reset
//   start         single-cycle request to begin a frame (ignored while busy)
//   stop          single-cycle request to halt after the current frame
//   pattern_in    Bayer pattern request (00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR)
//   frame_vsync   frame valid, high for the whole frame
//   frame_href    line valid
//   frame_clken   pixel enable, identical to frame_href
//   pixel_x       column of the current pixel (valid with frame_clken)
//   pixel_y       row of the current pixel (valid with frame_clken)
//   bayer_pattern pattern latched for the current frame
//   busy          high in every state except IDLE
//   frame_done    one-cycle pulse in the first cycle after vsync falls
//   frame_cnt     count of completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module raw_frame_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_GAP    = 20,
  parameter int CNT_W    = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       pattern_in,
  output logic             frame_vsync,
  output logic             frame_href,
  output logic             frame_clken,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic [1:0]       bayer_pattern,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    ACTIVE,
    BLANK,
    GAP
  } state_t;

  // Terminal counts: each timed state counts cnt from 0 up to its length - 1.
  localparam logic [CNT_W-1:0] HA_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VA_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VG_LAST = CNT_W'(V_GAP - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             stop_pending;

  // All outputs are registered. They are assigned together with the state
  // transition, so each output already reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      stop_pending  <= 1'b0;
      frame_vsync   <= 1'b0;
      frame_href    <= 1'b0;
      frame_clken   <= 1'b0;
      pixel_x       <= '0;
      pixel_y       <= '0;
      bayer_pattern <= 2'b00;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= 16'd0;
    end else begin
      frame_done <= 1'b0;

      // A stop only marks the request; the running frame always completes.
      if (stop && (state != IDLE)) begin
        stop_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          // stop_pending is cleared on every entry to IDLE, so it only acts
          // as a guard here.
          if (start && !stop && !stop_pending) begin
            state         <= LEAD;
            cnt           <= '0;
            bayer_pattern <= pattern_in;
            pixel_y       <= '0;
            frame_vsync   <= 1'b1;
            busy          <= 1'b1;
          end
        end

        LEAD: begin
          if (cnt == HB_LAST) begin
            state       <= ACTIVE;
            cnt         <= '0;
            pixel_x     <= '0;
            frame_href  <= 1'b1;
            frame_clken <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ACTIVE: begin
          if (cnt == HA_LAST) begin
            state       <= BLANK;
            cnt         <= '0;
            frame_href  <= 1'b0;
            frame_clken <= 1'b0;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            pixel_x <= cnt + CNT_W'(1);
          end
        end

        BLANK: begin
          if (cnt == HB_LAST) begin
            cnt <= '0;
            if (pixel_y == VA_LAST) begin
              state       <= GAP;
              frame_vsync <= 1'b0;
              frame_done  <= 1'b1;
              frame_cnt   <= frame_cnt + 16'd1;
            end else begin
              state       <= ACTIVE;
              pixel_y     <= pixel_y + CNT_W'(1);
              pixel_x     <= '0;
              frame_href  <= 1'b1;
              frame_clken <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt == VG_LAST) begin
            cnt <= '0;
`ifdef RAW_SEQ_CONT_EN
            // A stop arriving in the very last GAP cycle still halts here.
            if (!stop_pending && !stop) begin
              state         <= LEAD;
              bayer_pattern <= pattern_in;
              pixel_y       <= '0;
              frame_vsync   <= 1'b1;
            end else begin
              state        <= IDLE;
              busy         <= 1'b0;
              stop_pending <= 1'b0;
            end
`else
            state        <= IDLE;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raw_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_raw_frame_sequencer
//
// Directed self-checking bench for raw_frame_sequencer with H_ACTIVE=4,
// H_BLANK=2, V_ACTIVE=3, V_GAP=5. Expected strobes are derived from the frame
// timing (lead, line period, vsync high time, frame period) counted from the
// cycle after start is sampled. Covers both builds via RAW_SEQ_CONT_EN.
// -----------------------------------------------------------------------------
module tb_raw_frame_sequencer;

  localparam int HA      = 4;
  localparam int HB      = 2;
  localparam int VA      = 3;
  localparam int VG      = 5;
  localparam int CW      = 14;
  localparam int LP      = HA + HB;          // line period
  localparam int VS_HIGH = HB + VA * LP;     // 20
  localparam int FP      = VS_HIGH + VG;     // 25

`ifdef RAW_SEQ_CONT_EN
  // Continuous build needs a stop to turn a start into a single frame.
  localparam int SHOT_STOP_K = 12;
`else
  localparam int SHOT_STOP_K = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [1:0]    pattern_in;
  logic          frame_vsync;
  logic          frame_href;
  logic          frame_clken;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic [1:0]    bayer_pattern;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_cnt;

  int n_checks;
  int n_fail;

  raw_frame_sequencer #(
    .H_ACTIVE(HA),
    .H_BLANK (HB),
    .V_ACTIVE(VA),
    .V_GAP   (VG),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .pattern_in   (pattern_in),
    .frame_vsync  (frame_vsync),
    .frame_href   (frame_href),
    .frame_clken  (frame_clken),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .bayer_pattern(bayer_pattern),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request, let the next rising edge sample it, and return 1 ns
  // after that edge (the "T+1" observation point).
  task automatic applyStimulus(input logic s, input logic p, input logic [1:0] pat);
    start      = s;
    stop       = p;
    pattern_in = pat;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vsync"}, frame_vsync, 1'b0);
    checkOutput({tag, "_href"},  frame_href,  1'b0);
    checkOutput({tag, "_clken"}, frame_clken, 1'b0);
    checkOutput({tag, "_busy"},  busy,        1'b0);
    checkOutput({tag, "_done"},  frame_done,  1'b0);
    checkOutput({tag, "_px"},    pixel_x,     '0);
    checkOutput({tag, "_py"},    pixel_y,     '0);
    checkOutput({tag, "_pat"},   bayer_pattern, 2'b00);
    checkOutput({tag, "_fcnt"},  frame_cnt,   16'd0);
  endtask

  // Called right after the edge that sampled start. Walks k = 1..total and
  // compares against the frame timing. Optional extra start / stop / pattern
  // change are driven at cycles start_k / stop_k / pat_k (0 = none).
  task automatic runAndCheck(input int frames, input int total, input int start_k,
                             input int stop_k, input int pat_k,
                             input logic [1:0] pat0, input logic [1:0] pat1);
    for (int k = 1; k <= total; k++) begin
      int f, r, off, px, py;
      logic in_frame, e_vs, e_href, e_done, e_busy;
      logic [1:0] e_pat;
      f        = (k - 1) / FP;
      r        = (k - 1) % FP;
      in_frame = (f < frames);
      e_vs     = in_frame && (r < VS_HIGH);
      off      = r - HB;
      px       = (off >= 0) ? off % LP : 0;
      py       = (off >= 0) ? off / LP : 0;
      e_href   = in_frame && (off >= 0) && (off < VA * LP) && (px < HA);
      e_done   = in_frame && (r == VS_HIGH);
      e_busy   = (k <= frames * FP);
      e_pat    = (frames > 1 && k > FP) ? pat1 : pat0;

      checkOutput($sformatf("vsync@%0d", k), frame_vsync, e_vs);
      checkOutput($sformatf("href@%0d", k),  frame_href,  e_href);
      checkOutput($sformatf("clken@%0d", k), frame_clken, e_href);
      checkOutput($sformatf("busy@%0d", k),  busy,        e_busy);
      checkOutput($sformatf("done@%0d", k),  frame_done,  e_done);
      if (e_vs) checkOutput($sformatf("pat@%0d", k), bayer_pattern, e_pat);
      if (e_href) begin
        checkOutput($sformatf("px@%0d", k), pixel_x, px);
        checkOutput($sformatf("py@%0d", k), pixel_y, py);
      end

      start = (k == start_k);
      stop  = (k == stop_k);
      if (k == pat_k) pattern_in = pat1;
      stepCycle();
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    pattern_in = 2'b00;

    // Reset and idle
    repeat (3) stepCycle();
    checkAllZero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput($sformatf("idle_vsync%0d", i), frame_vsync, 1'b0);
      checkOutput($sformatf("idle_busy%0d", i),  busy,        1'b0);
    end
    checkAllZero("idle");

    // Single shot, pattern change mid-frame, ignored start while busy
    $display("[TB] single shot");
    applyStimulus(1'b1, 1'b0, 2'b01);
    runAndCheck(1, 26, 10, SHOT_STOP_K, 5, 2'b01, 2'b11);
    checkOutput("shot_fcnt", frame_cnt, 16'd1);
    checkOutput("shot_px_hold", pixel_x, HA - 1);
    checkOutput("shot_py_hold", pixel_y, VA - 1);
    checkOutput("shot_pat_hold", bayer_pattern, 2'b01);

    // start and stop together in IDLE stay idle
    $display("[TB] start+stop in idle");
    applyStimulus(1'b1, 1'b1, 2'b10);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("ss_busy%0d", i),  busy,        1'b0);
      checkOutput($sformatf("ss_vsync%0d", i), frame_vsync, 1'b0);
      stepCycle();
    end
    checkOutput("ss_pat", bayer_pattern, 2'b01);
    checkOutput("ss_fcnt", frame_cnt, 16'd1);

    // Async reset mid-ACTIVE, then a clean frame
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0, 2'b10);
    repeat (3) stepCycle();
    checkOutput("mid_href", frame_href, 1'b1);
    checkOutput("mid_px", pixel_x, 1);
    checkOutput("mid_pat", bayer_pattern, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'b00);
    runAndCheck(1, 26, 0, SHOT_STOP_K, 0, 2'b00, 2'b00);
    checkOutput("post_rst_fcnt", frame_cnt, 16'd1);

`ifdef RAW_SEQ_CONT_EN
    // Continuous: stop during frame 3 yields exactly 3 frames
    $display("[TB] continuous");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'b01);
    runAndCheck(3, 80, 0, 60, 5, 2'b01, 2'b11);
    checkOutput("cont_fcnt", frame_cnt, 16'd3);
`else
    // Single shot: stop mid-frame does not truncate, next start still works
    $display("[TB] single shot with stop");
    applyStimulus(1'b1, 1'b0, 2'b11);
    runAndCheck(1, 26, 0, 8, 0, 2'b11, 2'b11);
    checkOutput("stop_fcnt", frame_cnt, 16'd2);
    applyStimulus(1'b1, 1'b0, 2'b01);
    runAndCheck(1, 26, 0, 0, 0, 2'b01, 2'b01);
    checkOutput("after_stop_fcnt", frame_cnt, 16'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
